// File: rtl/attn_input_loader.sv
// Front end of the 8x8 attention engine: packs a 96-word key/query/value frame into
// flat buses, then enables the engine until it reports done or the watchdog expires.
module attn_input_loader #(
    parameter int DATA_W        = 16,
    parameter int WORDS_PER_MAT = 32,
    parameter int TIMEOUT       = 4096
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [DATA_W-1:0]               s_data,
    input  logic                            s_last,
    output logic [DATA_W*WORDS_PER_MAT-1:0] key,
    output logic [DATA_W*WORDS_PER_MAT-1:0] query,
    output logic [DATA_W*WORDS_PER_MAT-1:0] value,
    output logic                            attn_en,
    input  logic                            attn_all_done,
    output logic                            frame_done,
    output logic                            timeout,
    output logic                            err_len,
    output logic                            busy
);

    localparam int BUS_W = DATA_W * WORDS_PER_MAT;
    localparam int IDX_W = $clog2(WORDS_PER_MAT);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WORDS_PER_MAT - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);
    localparam bit WDOG_EN = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        LOAD_K = 3'd0,
        LOAD_Q = 3'd1,
        LOAD_V = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [IDX_W-1:0]  idx_r, idx_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              accept_s;
    logic              wr_k_s, wr_q_s, wr_v_s;
    logic              err_s, done_s, to_s;

    logic              s_ready_r, attn_en_r, frame_done_r, timeout_r, err_len_r, busy_r;
    logic [BUS_W-1:0]  key_r, query_r, value_r;

    // Next-state, word-index and run-counter logic plus event strobes
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        cnt_s    = cnt_r;
        wr_k_s   = 1'b0;
        wr_q_s   = 1'b0;
        wr_v_s   = 1'b0;
        err_s    = 1'b0;
        done_s   = 1'b0;
        to_s     = 1'b0;
        accept_s = s_valid && s_ready_r;
        case (state_r)
            LOAD_K, LOAD_Q, LOAD_V: begin
                if (accept_s) begin
                    wr_k_s = (state_r == LOAD_K);
                    wr_q_s = (state_r == LOAD_Q);
                    wr_v_s = (state_r == LOAD_V);
                    if (s_last && !((state_r == LOAD_V) && (idx_r == IDX_LAST))) begin
                        // Early end of frame: drop the partial frame and resynchronise
                        err_s   = 1'b1;
                        idx_s   = '0;
                        state_s = LOAD_K;
                    end else if (idx_r == IDX_LAST) begin
                        idx_s = '0;
                        if (state_r == LOAD_K) begin
                            state_s = LOAD_Q;
                        end else if (state_r == LOAD_Q) begin
                            state_s = LOAD_V;
                        end else begin
                            // Missing s_last is flagged but the full frame is still run
                            err_s   = !s_last;
                            state_s = RUN;
                        end
                    end else begin
                        idx_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    state_s = state_r;
                end
            end
            RUN: begin
                cnt_s = cnt_r + CNT_W'(1);
                if (attn_all_done) begin
                    done_s  = 1'b1;
                    state_s = DRAIN;
                end else if (WDOG_EN && (cnt_r == CNT_LIMIT)) begin
                    to_s    = 1'b1;
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                cnt_s   = '0;
                state_s = LOAD_K;
            end
            default: begin
                state_s = LOAD_K;
                idx_s   = '0;
                cnt_s   = '0;
            end
        endcase
    end

    // Control state and registered status outputs, derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= LOAD_K;
            idx_r        <= '0;
            cnt_r        <= '0;
            s_ready_r    <= 1'b0;
            attn_en_r    <= 1'b0;
            frame_done_r <= 1'b0;
            timeout_r    <= 1'b0;
            err_len_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            cnt_r        <= cnt_s;
            s_ready_r    <= (state_s == LOAD_K) || (state_s == LOAD_Q) || (state_s == LOAD_V);
            attn_en_r    <= (state_s == RUN);
            frame_done_r <= done_s;
            timeout_r    <= to_s;
            err_len_r    <= err_s;
            busy_r       <= !((state_s == LOAD_K) && (idx_s == '0));
        end
    end

    // Matrix buses: only the addressed word is written, so values hold through RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_r   <= '0;
            query_r <= '0;
            value_r <= '0;
        end else begin
            if (wr_k_s) begin
                key_r[DATA_W*idx_r +: DATA_W] <= s_data;
            end
            if (wr_q_s) begin
                query_r[DATA_W*idx_r +: DATA_W] <= s_data;
            end
            if (wr_v_s) begin
                value_r[DATA_W*idx_r +: DATA_W] <= s_data;
            end
        end
    end

    assign s_ready    = s_ready_r;
    assign attn_en    = attn_en_r;
    assign frame_done = frame_done_r;
    assign timeout    = timeout_r;
    assign err_len    = err_len_r;
    assign busy       = busy_r;
    assign key        = key_r;
    assign query      = query_r;
    assign value      = value_r;

endmodule
